encoder_rr_arbiter: RTL and testbench

//   Round-robin arbiter sharing one encoder datapath among up to 7 requesters.

---
 rtl/encoder_rr_arbiter_if.sv | 37 +++
 rtl/encoder_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_encoder_rr_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/encoder_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : encoder_rr_arbiter_if
// Brief    : Request/grant bundle between requesters and the shared encoder
//            arbiter; grant carried as one-hot, binary index and Gray index.
// Revision : 1.0 - initial release
// ============================================================================
interface encoder_rr_arbiter_if #(
    parameter int N_REQ = 7,
    parameter int IDX_W = 3
);
    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] gnt_gray;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx,
        input  gnt_gray
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_idx,
        output gnt_gray
    );
endinterface
`default_nettype wire

// File: rtl/encoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : encoder_rr_arbiter
// Brief    : Round-robin arbiter with hold limit; registered one-hot, binary
//            and Gray-coded grant outputs.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_rr_arbiter #(
    parameter int N_REQ    = 7,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    encoder_rr_arbiter_if.slave   bus
);

    localparam int c_HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    w_gnt_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [IDX_W-1:0]    r_gray;
    logic [IDX_W-1:0]    w_gray_nxt;
    logic                r_valid;
    logic                w_valid_nxt;

    logic [N_REQ-1:0]    w_search;
    logic                w_held;
    logic                w_hold_max;
    logic                w_found;
    logic [IDX_W-1:0]    w_win;
    logic                w_take;
    int                  w_k;

    // The current holder is masked out so a released or rotated index can
    // never win its own hand-off edge; in IDLE r_gnt is zero.
    assign w_search   = bus.req & ~r_gnt;
    assign w_held     = |(bus.req & r_gnt);
    assign w_hold_max = (MAX_HOLD != 0) && (r_hold == c_HOLD_W'(MAX_HOLD));

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = int'(r_ptr) + i;
            if (w_k >= N_REQ) begin
                w_k = w_k - N_REQ;
            end
            if (!w_found && w_search[w_k]) begin
                w_found = 1'b1;
                w_win   = IDX_W'(w_k);
            end
        end
    end

    // State register, including the registered outputs and arbitration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_gray  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_gray  <= w_gray_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (bus.en && w_found) begin
                    w_state_nxt = c_GRANT;
                    w_take      = 1'b1;
                end
            end
            c_GRANT: begin
                if (!w_held) begin
                    if (bus.en && w_found) begin
                        w_take = 1'b1;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end else if (w_hold_max && bus.en && w_found) begin
                    w_take = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_gray_nxt  = r_gray;
        w_valid_nxt = r_valid;
        if (w_take) begin
            w_ptr_nxt   = (w_win == IDX_W'(N_REQ - 1)) ? '0 : w_win + IDX_W'(1);
            w_hold_nxt  = c_HOLD_W'(1);
            w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
            w_idx_nxt   = w_win;
            w_gray_nxt  = w_win ^ (w_win >> 1);
            w_valid_nxt = 1'b1;
        end else if (w_state_nxt == c_GRANT) begin
            if ((MAX_HOLD != 0) && !w_hold_max) begin
                w_hold_nxt = r_hold + c_HOLD_W'(1);
            end
        end else begin
            w_hold_nxt  = '0;
            w_gnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_gray_nxt  = '0;
            w_valid_nxt = 1'b0;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = r_valid;
    assign bus.gnt_idx   = r_idx;
    assign bus.gnt_gray  = r_gray;

endmodule
`default_nettype wire

// File: tb/tb_encoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_encoder_rr_arbiter
// Brief    : Self-checking bench for encoder_rr_arbiter against a behavioural
//            round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_encoder_rr_arbiter;

    localparam int c_N    = 7;
    localparam int c_W    = 3;
    localparam int c_HOLD = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    // Reference model state: holder index (-1 = none), search start, hold age.
    int   m_g;
    int   m_ptr;
    int   m_hold;

    encoder_rr_arbiter_if #(.N_REQ(c_N), .IDX_W(c_W)) bus ();

    encoder_rr_arbiter #(
        .N_REQ    (c_N),
        .IDX_W    (c_W),
        .MAX_HOLD (c_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [c_N-1:0] v, input int start);
        for (int i = 0; i < c_N; i++) begin
            if (v[(start + i) % c_N]) return (start + i) % c_N;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_g    = w;
        m_ptr  = (w + 1) % c_N;
        m_hold = 1;
    endtask

    task automatic model_edge();
        logic [c_N-1:0] others;
        if (rst) begin
            m_g = -1; m_ptr = 0; m_hold = 0;
        end else if (m_g < 0) begin
            if (bus.en && (bus.req != 0)) model_grant(rr_pick(bus.req, m_ptr));
        end else begin
            others = bus.req;
            others[m_g] = 1'b0;
            if (!bus.req[m_g]) begin
                if (bus.en && (others != 0)) model_grant(rr_pick(others, m_ptr));
                else begin m_g = -1; m_hold = 0; end
            end else if (m_hold == c_HOLD && bus.en && (others != 0)) begin
                model_grant(rr_pick(others, m_ptr));
            end else if (m_hold < c_HOLD) begin
                m_hold++;
            end
        end
    endtask

    task automatic compare_model();
        int idx;
        idx = (m_g < 0) ? 0 : m_g;
        check("gnt",       32'(bus.gnt),       (m_g < 0) ? 32'd0 : (32'd1 << m_g));
        check("gnt_valid", 32'(bus.gnt_valid), (m_g < 0) ? 32'd0 : 32'd1);
        check("gnt_idx",   32'(bus.gnt_idx),   32'(idx));
        check("gnt_gray",  32'(bus.gnt_gray),  32'(idx ^ (idx >> 1)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [c_N-1:0] r;
        n_checks = 0; n_pass = 0;
        m_g = -1; m_ptr = 0; m_hold = 0;
        rst = 1'b1; bus.en = 1'b0; bus.req = '0;

        // Reset held for two cycles with every request asserted.
        bus.req = 7'h7F; bus.en = 1'b1;
        repeat (2) begin
            step();
            check("rst_gnt", 32'(bus.gnt), 32'd0);
        end
        rst = 1'b0; bus.req = '0;
        step();

        // Single request at index 3.
        bus.req = 7'b0001000;
        step();
        check("single_gnt",  32'(bus.gnt),      32'h08);
        check("single_gray", 32'(bus.gnt_gray), 32'b010);
        repeat (6) step();
        check("single_hold", 32'(bus.gnt_idx),  32'd3);

        // Full rotation with hold limit 4.
        do_reset();
        bus.req = 7'h7F;
        for (int c = 0; c < 32; c++) begin
            step();
            check("rot_idx", 32'(bus.gnt_idx), 32'((c / 4) % 7));
        end

        // Release handoff 5 -> 2 without an idle cycle.
        do_reset();
        bus.req = 7'b0100000;
        step();
        check("ho_first", 32'(bus.gnt_idx), 32'd5);
        bus.req = 7'b0100100;
        step();
        bus.req = 7'b0000100;
        step();
        check("ho_gnt",   32'(bus.gnt),       32'b0000100);
        check("ho_valid", 32'(bus.gnt_valid), 32'd1);

        // en gating after release.
        do_reset();
        bus.req = 7'b0000010;
        step();
        bus.en = 1'b0; bus.req = 7'b0010000;
        step();
        check("en_drop", 32'(bus.gnt), 32'd0);
        step();
        check("en_wait", 32'(bus.gnt), 32'd0);
        bus.en = 1'b1;
        step();
        check("en_back", 32'(bus.gnt), 32'b0010000);

        // Reset mid-grant clears the pointer.
        do_reset();
        bus.req = 7'b1000000;
        step();
        check("mid_g6", 32'(bus.gnt_idx), 32'd6);
        rst = 1'b1;
        step();
        check("mid_rst", 32'(bus.gnt), 32'd0);
        rst = 1'b0; bus.req = 7'h7F;
        step();
        check("mid_first", 32'(bus.gnt), 32'd1);

        // Randomised traffic with level-held requests, en toggling, rare reset.
        for (int c = 0; c < 600; c++) begin
            r = bus.req;
            for (int i = 0; i < c_N; i++) begin
                if (r[i] && (m_g == i) && ($urandom_range(0, 99) < 30)) r[i] = 1'b0;
                else if (!r[i] && ($urandom_range(0, 99) < 15)) r[i] = 1'b1;
                else if (r[i] && ($urandom_range(0, 99) < 3)) r[i] = 1'b0;
            end
            bus.req = r;
            bus.en  = ($urandom_range(0, 99) < 85);
            rst     = ($urandom_range(0, 99) < 2);
            step();
            check("onehot", 32'((bus.gnt & (bus.gnt - 1'b1)) == 0), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
